// File: rtl/ball_axis_ctrl.sv
// ball_axis_ctrl: single-axis ball motion controller for the Arkanoid core.
// One instance drives X and another drives Y. On every motion tick the
// ball advances by a variable step. It reflects off the walls without
// overshooting them, and it bounces on latched collisions. After each
// bounce, a lockout window stops the ball re-bouncing on the same object.
// Optional feature: define BALL_AXIS_SPEEDUP_EN to add a per-bounce speed
// offset. The offset grows by one per bounce, saturates, and is cleared by
// serve and by reset.
module ball_axis_ctrl #(
    parameter int POS_W         = 12,
    parameter int POS_MIN       = 10,
    parameter int POS_MAX       = 1013,
    parameter int POS_INIT      = 400,
    parameter bit DIR_INIT      = 1'b1,
    parameter int TICK_DIV      = 800000,
    parameter int CNT_W         = 20,
    parameter int SPD_W         = 3,
    parameter int COL_W         = 16,
    parameter int LOCKOUT_TICKS = 4
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             serve,
    input  logic             launch,
    input  logic             pause,
    input  logic [SPD_W-1:0] speed,
    input  logic [COL_W-1:0] collision_det,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             moving,
    output logic             bounce,
    output logic             wall_hit
);

    // One guard bit, so that pos+step and the reflection terms never wrap
    localparam int EXT_W  = POS_W + 1;
    localparam int LOCK_W = $clog2(LOCKOUT_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [LOCK_W-1:0]  lock_reg, lock_next;
    logic               latch_reg, latch_next;
    logic [POS_W-1:0]   pos_reg, pos_next;
    logic               dir_reg, dir_next;
    logic               bounce_reg, bounce_next;
    logic               wall_reg, wall_next;

    logic               running;
    logic               tick;
    logic               col_now;
    logic               col_hit;
    logic [SPD_W-1:0]   base_step;
    logic [SPD_W-1:0]   step;
    logic [EXT_W-1:0]   pos_ext;
    logic [EXT_W-1:0]   step_ext;
    logic [EXT_W-1:0]   up_sum;
    logic [EXT_W-1:0]   dn_pos;
    logic [EXT_W-1:0]   dn_lim;
    logic [EXT_W-1:0]   wall_up_pos;
    logic [EXT_W-1:0]   wall_dn_pos;

    // The counter only advances in RUN when pause is low, so a pause
    // freezes the tick phase exactly where it was
    assign running = (state_reg == ST_RUN) && !pause;
    assign tick    = running && (cnt_reg == CNT_W'(TICK_DIV - 1));
    assign col_now = (state_reg == ST_RUN) && (|collision_det);
    // A collision seen in the tick cycle itself still counts for that tick
    assign col_hit = latch_reg || col_now;

    // A speed of zero would stall the ball, so it is promoted to one
    assign base_step = (speed == '0) ? SPD_W'(1) : speed;

`ifdef BALL_AXIS_SPEEDUP_EN
    logic [SPD_W-1:0] off_reg, off_next;
    logic [SPD_W:0]   step_sum;
    assign step_sum = {1'b0, base_step} + {1'b0, off_reg};
    assign step     = step_sum[SPD_W] ? {SPD_W{1'b1}} : step_sum[SPD_W-1:0];
`else
    assign step = base_step;
`endif

    assign pos_ext     = {1'b0, pos_reg};
    assign step_ext    = EXT_W'(step);
    assign up_sum      = pos_ext + step_ext;
    assign dn_pos      = pos_ext - step_ext;
    assign dn_lim      = EXT_W'(POS_MIN) + step_ext;
    assign wall_up_pos = EXT_W'(2 * POS_MAX) - pos_ext - step_ext;
    assign wall_dn_pos = EXT_W'(2 * POS_MIN) - pos_ext + step_ext;

    // State register
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: serve first, then pause (which beats launch)
    always_comb begin
        state_next = state_reg;
        if (serve) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (launch && !pause) state_next = ST_RUN;
                ST_RUN:  if (pause)            state_next = ST_HOLD;
                ST_HOLD: if (!pause)           state_next = ST_RUN;
                default:                       state_next = ST_IDLE;
            endcase
        end
    end

    // Motion datapath: tick counter, collision latch, lockout and position update
    always_comb begin
        pos_next    = pos_reg;
        dir_next    = dir_reg;
        cnt_next    = cnt_reg;
        lock_next   = lock_reg;
        latch_next  = latch_reg;
        bounce_next = 1'b0;
        wall_next   = 1'b0;
`ifdef BALL_AXIS_SPEEDUP_EN
        off_next    = off_reg;
`endif
        if (serve) begin
            pos_next   = POS_W'(POS_INIT);
            dir_next   = DIR_INIT;
            cnt_next   = '0;
            lock_next  = '0;
            latch_next = 1'b0;
`ifdef BALL_AXIS_SPEEDUP_EN
            off_next   = '0;
`endif
        end else if (tick) begin
            cnt_next   = '0;
            latch_next = 1'b0;
            if (dir_reg && (up_sum >= EXT_W'(POS_MAX))) begin
                pos_next  = wall_up_pos[POS_W-1:0];
                dir_next  = 1'b0;
                wall_next = 1'b1;
            end else if (!dir_reg && (pos_ext <= dn_lim)) begin
                pos_next  = wall_dn_pos[POS_W-1:0];
                dir_next  = 1'b1;
                wall_next = 1'b1;
            end else if (col_hit && (lock_reg == '0)) begin
                // Flip the direction and move away. A bounce right next
                // to the opposite wall stops at that wall and does not
                // pass through it.
                dir_next = !dir_reg;
                if (dir_reg) begin
                    pos_next = (pos_ext < dn_lim) ? POS_W'(POS_MIN) : dn_pos[POS_W-1:0];
                end else begin
                    pos_next = (up_sum > EXT_W'(POS_MAX)) ? POS_W'(POS_MAX) : up_sum[POS_W-1:0];
                end
                bounce_next = 1'b1;
                lock_next   = LOCK_W'(LOCKOUT_TICKS);
`ifdef BALL_AXIS_SPEEDUP_EN
                off_next    = (off_reg == {SPD_W{1'b1}}) ? off_reg : off_reg + 1'b1;
`endif
            end else begin
                pos_next = dir_reg ? up_sum[POS_W-1:0] : dn_pos[POS_W-1:0];
            end
            if (!bounce_next && (lock_reg != '0)) lock_next = lock_reg - 1'b1;
        end else begin
            if (running) cnt_next   = cnt_reg + 1'b1;
            if (col_now) latch_next = 1'b1;
        end
    end

    // Datapath registers; reset drops any pending count, latch or lockout
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            pos_reg    <= POS_W'(POS_INIT);
            dir_reg    <= DIR_INIT;
            cnt_reg    <= '0;
            lock_reg   <= '0;
            latch_reg  <= 1'b0;
            bounce_reg <= 1'b0;
            wall_reg   <= 1'b0;
`ifdef BALL_AXIS_SPEEDUP_EN
            off_reg    <= '0;
`endif
        end else begin
            pos_reg    <= pos_next;
            dir_reg    <= dir_next;
            cnt_reg    <= cnt_next;
            lock_reg   <= lock_next;
            latch_reg  <= latch_next;
            bounce_reg <= bounce_next;
            wall_reg   <= wall_next;
`ifdef BALL_AXIS_SPEEDUP_EN
            off_reg    <= off_next;
`endif
        end
    end

    assign pos      = pos_reg;
    assign dir      = dir_reg;
    assign moving   = (state_reg == ST_RUN);
    assign bounce   = bounce_reg;
    assign wall_hit = wall_reg;

endmodule

// File: tb/tb_ball_axis_ctrl.sv
// tb_ball_axis_ctrl: self-checking bench for ball_axis_ctrl.
// A cycle-level reference model is built from the motion rules. It uses
// integer arithmetic. Directed scenarios run first, then randomized
// serve/launch/pause/speed/collision traffic. The async reset is also
// exercised mid-run. Build with BALL_AXIS_SPEEDUP_EN to cover the speed-up option.
module tb_ball_axis_ctrl;

    localparam int POS_W         = 12;
    localparam int POS_MIN       = 10;
    localparam int POS_MAX       = 100;
    localparam int POS_INIT      = 50;
    localparam bit DIR_INIT      = 1'b1;
    localparam int TICK_DIV      = 4;
    localparam int CNT_W         = 3;
    localparam int SPD_W         = 3;
    localparam int COL_W         = 16;
    localparam int LOCKOUT_TICKS = 2;
    localparam int SPD_MAX       = (1 << SPD_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic             pclk = 1'b0;
    logic             reset = 1'b0;
    logic             serve = 1'b0;
    logic             launch = 1'b0;
    logic             pause = 1'b0;
    logic [SPD_W-1:0] speed = '0;
    logic [COL_W-1:0] collision_det = '0;
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             moving;
    logic             bounce;
    logic             wall_hit;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_pos, m_mode, m_cnt, m_lock, m_off;
    bit m_dir, m_latch, m_bounce, m_wall;

    ball_axis_ctrl #(
        .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT),
        .DIR_INIT(DIR_INIT), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .SPD_W(SPD_W),
        .COL_W(COL_W), .LOCKOUT_TICKS(LOCKOUT_TICKS)
    ) dut (
        .pclk(pclk), .reset(reset), .serve(serve), .launch(launch), .pause(pause),
        .speed(speed), .collision_det(collision_det), .pos(pos), .dir(dir),
        .moving(moving), .bounce(bounce), .wall_hit(wall_hit)
    );

    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = POS_INIT; m_dir = DIR_INIT; m_mode = M_IDLE; m_cnt = 0;
        m_lock = 0; m_latch = 0; m_off = 0; m_bounce = 0; m_wall = 0;
    endtask

    // Advance the model by one clock, using the inputs currently applied
    task automatic model_step(input bit sv, input bit ln, input bit ps, input int spd, input bit colv);
        bit run_now, tick, hit;
        int s;
        m_bounce = 0;
        m_wall   = 0;
        if (sv) begin
            m_pos = POS_INIT; m_dir = DIR_INIT; m_mode = M_IDLE;
            m_cnt = 0; m_lock = 0; m_latch = 0; m_off = 0;
            $display("serve  pos=%0d dir=%0d", m_pos, m_dir);
            return;
        end
        run_now = (m_mode == M_RUN);
        tick    = run_now && !ps && (m_cnt == TICK_DIV - 1);
        if (tick) begin
            hit = m_latch || (run_now && colv);
            s = (spd == 0) ? 1 : spd;
`ifdef BALL_AXIS_SPEEDUP_EN
            s = s + m_off;
            if (s > SPD_MAX) s = SPD_MAX;
`endif
            if (m_dir && (m_pos + s >= POS_MAX)) begin
                m_pos = 2 * POS_MAX - m_pos - s; m_dir = 0; m_wall = 1;
            end else if (!m_dir && (m_pos <= POS_MIN + s)) begin
                m_pos = 2 * POS_MIN - m_pos + s; m_dir = 1; m_wall = 1;
            end else if (hit && m_lock == 0) begin
                m_dir = !m_dir;
                m_pos = m_dir ? m_pos + s : m_pos - s;
                if (m_pos > POS_MAX) m_pos = POS_MAX;
                if (m_pos < POS_MIN) m_pos = POS_MIN;
                m_bounce = 1;
                m_lock = LOCKOUT_TICKS;
                if (m_off < SPD_MAX) m_off++;
            end else begin
                m_pos = m_dir ? m_pos + s : m_pos - s;
            end
            if (!m_bounce && m_lock > 0) m_lock--;
            m_cnt = 0;
            m_latch = 0;
            $display("tick   step=%0d pos=%0d dir=%0d bounce=%0d wall=%0d", s, m_pos, m_dir, m_bounce, m_wall);
        end else begin
            if (run_now && colv) m_latch = 1;
            if (run_now && !ps) m_cnt++;
        end
        case (m_mode)
            M_IDLE:  if (ln && !ps) m_mode = M_RUN;
            M_RUN:   if (ps) m_mode = M_HOLD;
            default: if (!ps) m_mode = M_RUN;
        endcase
    endtask

    // One clock: update the model, let the edge pass, compare the outputs
    task automatic cycle();
        model_step(serve, launch, pause, int'(speed), collision_det != '0);
        @(posedge pclk);
        #1;
        check_val("pos",      int'(pos),      m_pos);
        check_val("dir",      int'(dir),      int'(m_dir));
        check_val("moving",   int'(moving),   int'(m_mode == M_RUN));
        check_val("bounce",   int'(bounce),   int'(m_bounce));
        check_val("wall_hit", int'(wall_hit), int'(m_wall));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        #12;
        check_val("rst_pos",    int'(pos),      POS_INIT);
        check_val("rst_dir",    int'(dir),      int'(DIR_INIT));
        check_val("rst_moving", int'(moving),   0);
        check_val("rst_bounce", int'(bounce),   0);
        check_val("rst_wall",   int'(wall_hit), 0);
        reset = 1'b1;

        // Launch at speed 1: the ball walks 51, 52, 53, one step every 4 cycles
        speed = 3'd1;
        launch = 1'b1;
        cycle();
        launch = 1'b0;
        idle_cycles(12);
        check_val("plan_walk", int'(pos), 53);

        // Pause mid-interval: the tick phase must survive the pause
        idle_cycles(2);
        pause = 1'b1;
        idle_cycles(10);
        pause = 1'b0;
        idle_cycles(8);

        // Collision pulse mid-interval, then a held collision inside lockout
        speed = 3'd2;
        idle_cycles(1);
        collision_det = 16'h0008;
        cycle();
        collision_det = '0;
        idle_cycles(4);
        collision_det = 16'h0100;
        idle_cycles(8);
        collision_det = '0;

        // Serve during RUN, then launch+pause together in IDLE must not start
        serve = 1'b1;
        cycle();
        serve = 1'b0;
        check_val("serve_pos", int'(pos), POS_INIT);
        launch = 1'b1;
        pause  = 1'b1;
        cycle();
        launch = 1'b0;
        pause  = 1'b0;
        check_val("launch_vs_pause", int'(moving), 0);
        idle_cycles(3);

        // Run at full speed into the walls
        launch = 1'b1;
        speed  = 3'd7;
        cycle();
        launch = 1'b0;
        idle_cycles(80);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            serve  = ($urandom_range(0, 299) == 0);
            launch = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) pause = ~pause;
            if ($urandom_range(0, 15) == 0) speed = SPD_W'($urandom);
            collision_det = ($urandom_range(0, 11) == 0) ? COL_W'($urandom) : '0;
            cycle();
        end
        serve = 1'b0; launch = 1'b0; pause = 1'b0; collision_det = '0;

        // Async reset asserted between clock edges while the ball is moving
        launch = 1'b1;
        speed  = 3'd3;
        cycle();
        launch = 1'b0;
        collision_det = 16'h0001;
        idle_cycles(6);
        collision_det = '0;
        #2 reset = 1'b0;
        #1;
        check_val("arst_pos",    int'(pos),      POS_INIT);
        check_val("arst_dir",    int'(dir),      int'(DIR_INIT));
        check_val("arst_moving", int'(moving),   0);
        check_val("arst_bounce", int'(bounce),   0);
        check_val("arst_wall",   int'(wall_hit), 0);
        model_reset();
        #1 reset = 1'b1;
        launch = 1'b1;
        speed  = 3'd1;
        cycle();
        launch = 1'b0;
        idle_cycles(12);
        check_val("post_rst_walk", int'(pos), 53);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
